fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/op_len_decode.sv | 25 ++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and the fetch state encoding.
package cpu_pkg;

  // Two-byte immediate forms
  localparam logic [7:0] OP_MOVI_LO = 8'hB8;
  localparam logic [7:0] OP_MOVI_HI = 8'hBF;
  localparam logic [7:0] OP_ADDI_LO = 8'h80;
  localparam logic [7:0] OP_ADDI_HI = 8'h87;

  // Three-byte control transfers (opcode + 16-bit target)
  localparam logic [7:0] OP_JMP_LO  = 8'hE0;
  localparam logic [7:0] OP_JMP_HI  = 8'hEF;
  localparam logic [7:0] OP_CALL    = 8'hF9;

  // Single-byte opcodes with special meaning elsewhere in the core
  localparam logic [7:0] OP_RET     = 8'hFB;
  localparam logic [7:0] OP_NOP     = 8'hFC;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  typedef enum logic [2:0] {
    ST_OPC  = 3'd0,
    ST_B1   = 3'd1,
    ST_B2   = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/op_len_decode.sv
// Instruction length decoder: opcode byte in, byte count (1..3) out.
// Purely combinational so the execute stage can reuse it.
module op_len_decode (
  input  logic [7:0] opcode,
  output logic [1:0] len
);
  import cpu_pkg::*;

  // Classify the opcode into its instruction length
  always_comb begin
    len = 2'd1;
    if ((opcode >= OP_MOVI_LO) && (opcode <= OP_MOVI_HI)) begin
      len = 2'd2;
    end else if ((opcode >= OP_ADDI_LO) && (opcode <= OP_ADDI_HI)) begin
      len = 2'd2;
    end else if (((opcode >= OP_JMP_LO) && (opcode <= OP_JMP_HI)) || (opcode == OP_CALL)) begin
      len = 2'd3;
    end else if ((opcode == OP_RET) || (opcode == OP_NOP) || (opcode == OP_HALT)) begin
      len = 2'd1;
    end else begin
      len = 2'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: reads opcode and operand bytes from a
// shared memory port, presents the assembled instruction with a
// valid/ready handshake, stops on HALT and restarts on redirect.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_dout,
  input  logic        mem_busy,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_op1,
  output logic [7:0]  instr_op2,
  output logic [1:0]  instr_len,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);
  import cpu_pkg::*;

  fetch_state_e state_r, state_nxt_s;
  logic [15:0]  pc_r, pc_nxt_s;
  logic [7:0]   opc_r, opc_nxt_s;
  logic [7:0]   op1_r, op1_nxt_s;
  logic [7:0]   op2_r, op2_nxt_s;
  logic [1:0]   len_r, len_nxt_s;
  logic [15:0]  ipc_r, ipc_nxt_s;
  logic         valid_r, valid_nxt_s;
  logic         halted_r, halted_nxt_s;
  logic [1:0]   dec_len_s;

  // Only the OPC state consumes the decoded length, and there the
  // opcode is the byte currently on the memory bus.
  op_len_decode u_len (
    .opcode (mem_dout),
    .len    (dec_len_s)
  );

  // State register and captured instruction fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_OPC;
      pc_r     <= 16'h0000;
      opc_r    <= 8'h00;
      op1_r    <= 8'h00;
      op2_r    <= 8'h00;
      len_r    <= 2'd1;
      ipc_r    <= 16'h0000;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      opc_r    <= opc_nxt_s;
      op1_r    <= op1_nxt_s;
      op2_r    <= op2_nxt_s;
      len_r    <= len_nxt_s;
      ipc_r    <= ipc_nxt_s;
      valid_r  <= valid_nxt_s;
      halted_r <= halted_nxt_s;
    end
  end

  // Next-state, byte capture and pc advance; redirect overrides all
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    opc_nxt_s   = opc_r;
    op1_nxt_s   = op1_r;
    op2_nxt_s   = op2_r;
    len_nxt_s   = len_r;
    ipc_nxt_s   = ipc_r;
    if (redirect) begin
      state_nxt_s = ST_OPC;
      pc_nxt_s    = redirect_pc;
      opc_nxt_s   = 8'h00;
      op1_nxt_s   = 8'h00;
      op2_nxt_s   = 8'h00;
      len_nxt_s   = 2'd1;
      ipc_nxt_s   = redirect_pc;
    end else begin
      case (state_r)
        ST_OPC: begin
          if (!mem_busy) begin
            opc_nxt_s   = mem_dout;
            op1_nxt_s   = 8'h00;
            op2_nxt_s   = 8'h00;
            len_nxt_s   = dec_len_s;
            ipc_nxt_s   = pc_r;
            pc_nxt_s    = pc_r + 16'd1;
            state_nxt_s = (dec_len_s == 2'd1) ? ST_HOLD : ST_B1;
          end else begin
            state_nxt_s = ST_OPC;
          end
        end
        ST_B1: begin
          if (!mem_busy) begin
            op1_nxt_s   = mem_dout;
            pc_nxt_s    = pc_r + 16'd1;
            state_nxt_s = (len_r == 2'd3) ? ST_B2 : ST_HOLD;
          end else begin
            state_nxt_s = ST_B1;
          end
        end
        ST_B2: begin
          if (!mem_busy) begin
            op2_nxt_s   = mem_dout;
            pc_nxt_s    = pc_r + 16'd1;
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_B2;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            state_nxt_s = (opc_r == OP_HALT) ? ST_HALT : ST_OPC;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_HALT: begin
          state_nxt_s = ST_HALT;
        end
        default: begin
          state_nxt_s = ST_OPC;
        end
      endcase
    end
    valid_nxt_s  = (state_nxt_s == ST_HOLD);
    halted_nxt_s = (state_nxt_s == ST_HALT);
  end

  assign mem_addr     = pc_r;
  assign instr_valid  = valid_r;
  assign instr_opcode = opc_r;
  assign instr_op1    = op1_r;
  assign instr_op2    = op2_r;
  assign instr_len    = len_r;
  assign instr_pc     = ipc_r;
  assign halted       = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: byte memory model, scoreboard of
// expected instructions popped on each valid/ready transfer.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_busy = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode, instr_op1, instr_op2;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  logic [7:0] mem [0:65535];
  assign mem_dout = mem[mem_addr];

  typedef struct packed {
    logic [7:0]  opc;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .mem_busy     (mem_busy),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_op1    (instr_op1),
    .instr_op2    (instr_op2),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] opc, input logic [7:0] op1, input logic [7:0] op2,
                          input logic [1:0] len, input logic [15:0] pc);
    exp_t e;
    e.opc = opc; e.op1 = op1; e.op2 = op2; e.len = len; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // Bounded wait for instr_valid; checks the number of cycles it took
  task automatic wait_valid(input string tag, input int exp_n);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, n, exp_n);
  endtask

  task automatic redirect_to(input logic [15:0] addr);
    redirect    = 1'b1;
    redirect_pc = addr;
    tick();
    redirect    = 1'b0;
  endtask

  // Scoreboard: compare the presented instruction on every transfer
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      check_eq("sb_expected_avail", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("sb_opcode", {24'd0, instr_opcode}, {24'd0, mon_e.opc});
        check_eq("sb_op1",    {24'd0, instr_op1},    {24'd0, mon_e.op1});
        check_eq("sb_op2",    {24'd0, instr_op2},    {24'd0, mon_e.op2});
        check_eq("sb_len",    {30'd0, instr_len},    {30'd0, mon_e.len});
        check_eq("sb_pc",     {16'd0, instr_pc},     {16'd0, mon_e.pc});
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hFC;
    mem[16'h0000] = 8'hBB; mem[16'h0001] = 8'h05;
    mem[16'h0002] = 8'hF9; mem[16'h0003] = 8'h00; mem[16'h0004] = 8'h02;
    mem[16'h0005] = 8'hFC; mem[16'h0006] = 8'hFF;
    mem[16'h0200] = 8'hFC; mem[16'h0201] = 8'hBA; mem[16'h0202] = 8'h5A;
    mem[16'h020B] = 8'hE8; mem[16'h020C] = 8'h02; mem[16'h020D] = 8'h04;
    mem[16'hFFFF] = 8'hBC;

    // Reset values
    tick(); tick();
    check_eq("rst_valid",  {31'd0, instr_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_opcode", {24'd0, instr_opcode}, 32'd0);
    check_eq("rst_len",    {30'd0, instr_len}, 32'd1);
    check_eq("rst_pc",     {16'd0, instr_pc}, 32'd0);
    check_eq("rst_addr",   {16'd0, mem_addr}, 32'd0);

    // MOVI at 0x0000, valid two cycles after reset release
    instr_ready = 1'b1;
    push_exp(8'hBB, 8'h05, 8'h00, 2'd2, 16'h0000);
    rst = 1'b0;
    wait_valid("lat_movi_reset", 2);
    tick();

    // CALL at 0x0002, redirect in the cycle after acceptance
    push_exp(8'hF9, 8'h00, 8'h02, 2'd3, 16'h0002);
    wait_valid("lat_call", 3);
    tick();
    redirect_to(16'h0200);

    // NOP at 0x0200: no stale operand bytes from the CALL
    push_exp(8'hFC, 8'h00, 8'h00, 2'd1, 16'h0200);
    wait_valid("lat_nop", 1);
    tick();

    // MOVI at 0x0201 with memory busy for 3 cycles during B1
    push_exp(8'hBA, 8'h5A, 8'h00, 2'd2, 16'h0201);
    tick();
    mem_busy = 1'b1;
    tick(); tick(); tick();
    check_eq("busy_addr_hold", {16'd0, mem_addr}, 32'h0202);
    check_eq("busy_no_valid",  {31'd0, instr_valid}, 32'd0);
    mem_busy = 1'b0;
    wait_valid("lat_busy_tail", 1);
    tick();

    // Redirect together with busy: redirect wins; JUMP held by ready=0
    instr_ready = 1'b0;
    mem_busy = 1'b1;
    redirect_to(16'h020B);
    mem_busy = 1'b0;
    push_exp(8'hE8, 8'h02, 8'h04, 2'd3, 16'h020B);
    wait_valid("lat_jmp", 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("hold_valid",  {31'd0, instr_valid}, 32'd1);
      check_eq("hold_opcode", {24'd0, instr_opcode}, 32'hE8);
      check_eq("hold_op1",    {24'd0, instr_op1}, 32'h02);
      check_eq("hold_op2",    {24'd0, instr_op2}, 32'h04);
      check_eq("hold_len",    {30'd0, instr_len}, 32'd3);
      check_eq("hold_pc",     {16'd0, instr_pc}, 32'h020B);
      check_eq("hold_addr",   {16'd0, mem_addr}, 32'h020E);
    end
    instr_ready = 1'b1;
    tick();

    // HALT at 0x0006
    redirect_to(16'h0006);
    push_exp(8'hFF, 8'h00, 8'h00, 2'd1, 16'h0006);
    wait_valid("lat_halt", 1);
    tick();
    for (int k = 0; k < 10; k++) begin
      check_eq("halt_flag",  {31'd0, halted}, 32'd1);
      check_eq("halt_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("halt_pc",    {16'd0, mem_addr}, 32'h0007);
      tick();
    end
    redirect_to(16'h0000);
    check_eq("unhalt", {31'd0, halted}, 32'd0);
    push_exp(8'hBB, 8'h05, 8'h00, 2'd2, 16'h0000);
    wait_valid("lat_refetch", 2);
    tick();

    // MOVI straddling the 0xFFFF -> 0x0000 wrap
    mem[16'h0000] = 8'h07; mem[16'h0001] = 8'hFC;
    redirect_to(16'hFFFF);
    push_exp(8'hBC, 8'h07, 8'h00, 2'd2, 16'hFFFF);
    wait_valid("lat_wrap", 2);
    check_eq("wrap_next_addr", {16'd0, mem_addr}, 32'h0001);
    tick();
    push_exp(8'hFC, 8'h00, 8'h00, 2'd1, 16'h0001);
    wait_valid("lat_after_wrap", 1);

    // Transfer and redirect at the same edge
    redirect    = 1'b1;
    redirect_pc = 16'h020B;
    tick();
    redirect    = 1'b0;
    check_eq("xfer_redir_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("xfer_redir_addr",  {16'd0, mem_addr}, 32'h020B);

    // Reset in the middle of the JUMP, then restart at 0x0000
    tick();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid",  {31'd0, instr_valid}, 32'd0);
    check_eq("mid_rst_addr",   {16'd0, mem_addr}, 32'd0);
    check_eq("mid_rst_opcode", {24'd0, instr_opcode}, 32'd0);
    check_eq("mid_rst_len",    {30'd0, instr_len}, 32'd1);
    mem[16'h0000] = 8'hBB; mem[16'h0001] = 8'h05;
    tick();
    push_exp(8'hBB, 8'h05, 8'h00, 2'd2, 16'h0000);
    rst = 1'b0;
    wait_valid("lat_after_rst", 2);
    tick();
    instr_ready = 1'b0;

    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
